// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter
// Shares the single GPIO device register port between NumHosts bus hosts.
// Arbitration is round-robin or fixed-priority, and the grant is given in the
// same cycle as the request. Each one-cycle-latency device response is routed
// back to the host that issued it. A per-host lock keeps the port reserved for
// one host so it can do an atomic read-modify-write, and a timeout breaks any
// lock that is held too long.
//
// Handshake: a host raises host_req_i together with addr/we/be/wdata and holds
// all of them stable until host_gnt_o for that host is high in the same cycle.
// The transfer happens in the cycle where req & gnt are both high; there is no
// separate ready. The device sees device_req_o in that same cycle. The device
// answers with device_rvalid_i exactly one cycle later. host_rvalid_o then
// pulses for the issuing host, and host_rdata_o is valid with it.

module gpio_bus_arbiter #(
    parameter int unsigned NumHosts    = 2,
    parameter bit          RoundRobin  = 1'b1,
    parameter int unsigned LockTimeout = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumHosts-1:0]      host_req_i,
    input  logic [NumHosts-1:0]      host_lock_i,
    input  logic [NumHosts*32-1:0]   host_addr_i,
    input  logic [NumHosts-1:0]      host_we_i,
    input  logic [NumHosts*4-1:0]    host_be_i,
    input  logic [NumHosts*32-1:0]   host_wdata_i,
    output logic [NumHosts-1:0]      host_gnt_o,
    output logic [NumHosts-1:0]      host_rvalid_o,
    output logic [31:0]              host_rdata_o,
    output logic                     device_req_o,
    output logic [31:0]              device_addr_o,
    output logic                     device_we_o,
    output logic [3:0]               device_be_o,
    output logic [31:0]              device_wdata_o,
    input  logic                     device_rvalid_i,
    input  logic [31:0]              device_rdata_i,
    output logic                     lock_err_o
);

    localparam int unsigned IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam int unsigned CntW = (LockTimeout > 1) ? $clog2(LockTimeout) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(LockTimeout - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumHosts - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] lock_owner_q, lock_owner_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            lock_err_q, lock_err_d;
    logic [IdxW-1:0] rr_ptr_q;
    logic            resp_valid_q;
    logic [IdxW-1:0] resp_idx_q;

    logic [NumHosts-1:0] rr_mask;
    logic [NumHosts-1:0] req_above_ptr;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_any;
    logic                win_valid;
    logic [IdxW-1:0]     win_idx;
    logic                grant_en;

    // Index of the lowest set bit of v; 0 when v is empty.
    function automatic logic [IdxW-1:0] lowest_idx(input logic [NumHosts-1:0] v);
        logic [IdxW-1:0] idx;
        idx = '0;
        for (int i = NumHosts - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IdxW'(i);
            end
        end
        return idx;
    endfunction

    // Free arbitration. Round-robin first looks at requesters above the last
    // winner and falls back to the lowest requester, which gives the wrap.
    always_comb begin
        rr_mask = '0;
        for (int i = 0; i < NumHosts; i++) begin
            rr_mask[i] = (IdxW'(i) > rr_ptr_q);
        end
        req_above_ptr = host_req_i & rr_mask;
        arb_any       = |host_req_i;
        if (RoundRobin && (|req_above_ptr)) begin
            arb_idx = lowest_idx(req_above_ptr);
        end else begin
            arb_idx = lowest_idx(host_req_i);
        end
    end

    // Lock FSM next state and winner selection. While locked, only the owner
    // can win. The timeout cycle itself grants nobody, even if the owner is
    // requesting.
    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        lock_err_d   = lock_err_q;
        win_valid    = 1'b0;
        win_idx      = arb_idx;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    win_valid = 1'b1;
                    win_idx   = arb_idx;
                    if (host_lock_i[arb_idx]) begin
                        state_d      = LOCKED;
                        lock_owner_d = arb_idx;
                        lock_cnt_d   = '0;
                    end
                end
            end
            LOCKED: begin
                win_idx    = lock_owner_q;
                lock_cnt_d = (lock_cnt_q == CntMax) ? lock_cnt_q : lock_cnt_q + 1'b1;
                if (lock_cnt_q == CntMax) begin
                    state_d    = IDLE;
                    lock_err_d = 1'b1;
                end else if (host_req_i[lock_owner_q]) begin
                    win_valid = 1'b1;
                    if (!host_lock_i[lock_owner_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Nothing is granted while reset is held, so all outputs stay quiet.
    assign grant_en = win_valid & rst_ni;

    // One-hot grant and device request mux. The device bus is driven to zero
    // when there is no grant.
    always_comb begin
        host_gnt_o     = '0;
        device_addr_o  = '0;
        device_we_o    = 1'b0;
        device_be_o    = '0;
        device_wdata_o = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (grant_en && (win_idx == IdxW'(i))) begin
                host_gnt_o[i]  = 1'b1;
                device_addr_o  = host_addr_i[32*i +: 32];
                device_we_o    = host_we_i[i];
                device_be_o    = host_be_i[4*i +: 4];
                device_wdata_o = host_wdata_i[32*i +: 32];
            end
        end
    end

    assign device_req_o = grant_en;

    // Steer the device response to the host that was granted one cycle earlier.
    always_comb begin
        host_rvalid_o = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (resp_valid_q && device_rvalid_i && (resp_idx_q == IdxW'(i))) begin
                host_rvalid_o[i] = 1'b1;
            end
        end
    end

    assign host_rdata_o = rst_ni ? device_rdata_i : '0;
    assign lock_err_o   = lock_err_q;

    // Lock FSM state, owner, hold counter and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
            lock_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_err_q   <= lock_err_d;
        end
    end

    // Round-robin pointer and response tag. They follow every grant, and an
    // asynchronous reset drops any response that is still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= LastIdx;
            resp_valid_q <= 1'b0;
            resp_idx_q   <= '0;
        end else begin
            resp_valid_q <= grant_en;
            if (grant_en) begin
                rr_ptr_q   <= win_idx;
                resp_idx_q <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter
// Two instances: a round-robin arbiter checked every cycle against a
// behavioural model, and a fixed-priority arbiter for the priority scenario.
// Both use LockTimeout=8. The device is a simple responder whose read data is
// the address times 15.

module tb_gpio_bus_arbiter;

    localparam int NH = 2;
    localparam int LT = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // round-robin instance signals
    logic [NH-1:0]    req, lock, we;
    logic [NH*32-1:0] addr, wdata;
    logic [NH*4-1:0]  be;
    logic [NH-1:0]    gnt, rvalid;
    logic [31:0]      rdata;
    logic             dreq, dwe, lock_err;
    logic [31:0]      daddr, dwdata;
    logic [3:0]       dbe;
    logic             dev_rvalid_r, force_rv, dev_rvalid;
    logic [31:0]      dev_rdata;

    // fixed-priority instance signals
    logic [NH-1:0]    fp_req, fp_lock, fp_we;
    logic [NH*32-1:0] fp_addr, fp_wdata;
    logic [NH*4-1:0]  fp_be;
    logic [NH-1:0]    fp_gnt, fp_rvalid;
    logic [31:0]      fp_rdata, fp_daddr, fp_dwdata;
    logic             fp_dreq, fp_dwe, fp_lock_err, fp_dev_rvalid;
    logic [3:0]       fp_dbe;

    gpio_bus_arbiter #(.NumHosts(NH), .RoundRobin(1'b1), .LockTimeout(LT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(req), .host_lock_i(lock), .host_addr_i(addr),
        .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata),
        .host_gnt_o(gnt), .host_rvalid_o(rvalid), .host_rdata_o(rdata),
        .device_req_o(dreq), .device_addr_o(daddr), .device_we_o(dwe),
        .device_be_o(dbe), .device_wdata_o(dwdata),
        .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata),
        .lock_err_o(lock_err)
    );

    gpio_bus_arbiter #(.NumHosts(NH), .RoundRobin(1'b0), .LockTimeout(LT)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(fp_req), .host_lock_i(fp_lock), .host_addr_i(fp_addr),
        .host_we_i(fp_we), .host_be_i(fp_be), .host_wdata_i(fp_wdata),
        .host_gnt_o(fp_gnt), .host_rvalid_o(fp_rvalid), .host_rdata_o(fp_rdata),
        .device_req_o(fp_dreq), .device_addr_o(fp_daddr), .device_we_o(fp_dwe),
        .device_be_o(fp_dbe), .device_wdata_o(fp_dwdata),
        .device_rvalid_i(fp_dev_rvalid), .device_rdata_i(32'h0),
        .lock_err_o(fp_lock_err)
    );

    // device responders: answer one cycle after each request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_rvalid_r  <= 1'b0;
            dev_rdata     <= 32'h0;
            fp_dev_rvalid <= 1'b0;
        end else begin
            dev_rvalid_r  <= dreq;
            fp_dev_rvalid <= fp_dreq;
            if (dreq) dev_rdata <= daddr * 32'd15;
        end
    end
    assign dev_rvalid = dev_rvalid_r | force_rv;

    // scoreboard counters
    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_owner, m_age, m_ptr, m_last_win;
    bit          m_err, m_pv;
    int          m_pi;
    logic [31:0] m_paddr;
    logic [NH-1:0] obs_gnt, obs_rvalid;
    logic [31:0]   obs_rdata;
    logic          obs_err;
    bit            pend [NH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_ptr = NH - 1; m_err = 0;
        m_pv = 0; m_pi = 0; m_paddr = '0; m_last_win = -1;
    endtask

    // driver: program one host's request lines
    task automatic set_host(input int h, input bit r, input bit l, input bit w,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req[h] = r; lock[h] = l; we[h] = w;
        addr[h*32 +: 32] = a; wdata[h*32 +: 32] = d; be[h*4 +: 4] = b;
    endtask

    // one clock of the round-robin instance: check at negedge, advance model at posedge
    task automatic cycle();
        int win;
        bit tmo;
        @(negedge clk);
        win = -1; tmo = 0;
        if (m_owner >= 0) begin
            if (m_age == LT - 1) tmo = 1;
            else if (req[m_owner]) win = m_owner;
        end else begin
            for (int k = 1; k <= NH; k++) begin
                int c;
                c = (m_ptr + k) % NH;
                if (win < 0 && req[c]) win = c;
            end
        end
        obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata; obs_err = lock_err;
        check("gnt", 32'(gnt), (win >= 0) ? (32'd1 << win) : 32'd0);
        check("dev_req", 32'(dreq), (win >= 0) ? 32'd1 : 32'd0);
        if (win >= 0) begin
            check("dev_addr", daddr, addr[win*32 +: 32]);
            check("dev_wdata", dwdata, wdata[win*32 +: 32]);
            check("dev_we_be", {27'b0, dwe, dbe}, {27'b0, we[win], be[win*4 +: 4]});
        end else begin
            check("dev_idle", daddr | dwdata | {27'b0, dwe, dbe}, 32'd0);
        end
        check("rvalid", 32'(rvalid), m_pv ? (32'd1 << m_pi) : 32'd0);
        if (m_pv) check("rdata", rdata, m_paddr * 32'd15);
        check("lock_err", 32'(lock_err), 32'(m_err));
        @(posedge clk);
        if (tmo) begin
            m_err = 1; m_owner = -1;
        end else if (m_owner >= 0) begin
            if (win >= 0 && !lock[win]) m_owner = -1;
            m_age = (m_age + 1 > LT - 1) ? LT - 1 : m_age + 1;
        end else if (win >= 0 && lock[win]) begin
            m_owner = win; m_age = 0;
        end
        m_pv = (win >= 0);
        if (win >= 0) begin
            m_ptr = win; m_pi = win; m_paddr = addr[win*32 +: 32];
        end
        m_last_win = win;
        #1;
    endtask

    // one clock of the fixed-priority instance
    task automatic fp_cycle(input logic [NH-1:0] exp_gnt, input logic [NH-1:0] exp_rv);
        @(negedge clk);
        check("fp_gnt", 32'(fp_gnt), 32'(exp_gnt));
        check("fp_rvalid", 32'(fp_rvalid), 32'(exp_rv));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state: requests and a device response are present, outputs must stay 0
        rst_n = 1'b0; force_rv = 1'b1;
        req = '1; lock = '1; we = '1; addr = '1; wdata = '1; be = '1;
        fp_req = '1; fp_lock = '0; fp_we = '0; fp_addr = '0; fp_wdata = '0; fp_be = '1;
        model_reset();
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_dev", {31'b0, dreq} | daddr | dwdata, 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_lock_err", 32'(lock_err), 32'd0);
        check("rst_fp_gnt", 32'(fp_gnt), 32'd0);
        force_rv = 1'b0; req = '0; lock = '0; fp_req = '0;
        @(posedge clk); #1 rst_n = 1'b1;

        // single host write
        set_host(0, 1, 0, 1, 32'h0, 32'h0000_00A5, 4'hF);
        cycle();
        check("single_gnt", 32'(obs_gnt), 32'h1);
        req = '0;
        cycle();
        check("single_rvalid", 32'(obs_rvalid), 32'h1);

        // round-robin from a fresh reset: 0,1,0,1
        rst_n = 1'b0; model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        set_host(0, 1, 0, 0, 32'h10, 32'h0, 4'hF);
        set_host(1, 1, 0, 0, 32'h20, 32'h0, 4'hF);
        cycle(); check("rr_gnt_a", 32'(obs_gnt), 32'h1);
        cycle(); check("rr_gnt_b", 32'(obs_gnt), 32'h2); check("rr_rv_b", 32'(obs_rvalid), 32'h1);
        cycle(); check("rr_gnt_c", 32'(obs_gnt), 32'h1); check("rr_rv_c", 32'(obs_rvalid), 32'h2);
        cycle(); check("rr_gnt_d", 32'(obs_gnt), 32'h2); check("rr_rv_d", 32'(obs_rvalid), 32'h1);
        req = '0;
        cycle(); check("rr_rv_e", 32'(obs_rvalid), 32'h2);

        // read routing: host1 reads 0x4, device returns 0x3C
        set_host(1, 1, 0, 0, 32'h4, 32'h0, 4'hF);
        cycle(); check("rd_gnt", 32'(obs_gnt), 32'h2);
        req = '0;
        cycle(); check("rd_rvalid", 32'(obs_rvalid), 32'h2); check("rd_rdata", obs_rdata, 32'h3C);

        // lock with normal release
        set_host(0, 1, 1, 0, 32'h0, 32'h0, 4'hF);
        cycle(); check("lk_acq", 32'(obs_gnt), 32'h1);
        req[0] = 1'b0;
        set_host(1, 1, 0, 1, 32'h8, 32'h1234, 4'h3);
        for (int i = 0; i < 3; i++) begin
            cycle(); check("lk_stall", 32'(obs_gnt), 32'h0);
        end
        set_host(0, 1, 0, 1, 32'h0, 32'h00FF, 4'hF);
        cycle(); check("lk_unlock", 32'(obs_gnt), 32'h1);
        req[0] = 1'b0;
        cycle(); check("lk_h1", 32'(obs_gnt), 32'h2); check("lk_err", 32'(obs_err), 32'h0);
        req = '0;
        cycle();

        // lock timeout: host0 locks and goes idle, dropping lock while idle
        set_host(0, 1, 1, 0, 32'h0, 32'h0, 4'hF);
        cycle(); check("to_acq", 32'(obs_gnt), 32'h1);
        req[0] = 1'b0; lock[0] = 1'b0;
        set_host(1, 1, 0, 0, 32'hC, 32'h0, 4'hF);
        for (int i = 0; i < LT; i++) begin
            cycle(); check("to_stall", 32'(obs_gnt), 32'h0);
        end
        cycle(); check("to_h1", 32'(obs_gnt), 32'h2); check("to_err", 32'(obs_err), 32'h1);
        req = '0;
        repeat (3) cycle();
        check("to_err_sticky", 32'(obs_err), 32'h1);

        // reset during a pending response
        set_host(1, 1, 0, 0, 32'h8, 32'h0, 4'hF);
        cycle();
        req = '0; rst_n = 1'b0; force_rv = 1'b1; model_reset();
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_err", 32'(lock_err), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rvalid", 32'(rvalid), 32'd0);
        force_rv = 1'b0;
        @(posedge clk); #1;

        // fixed priority: host0 wins while requesting, host1 next
        fp_req = 2'b11;
        fp_cycle(2'b01, 2'b00);
        fp_cycle(2'b01, 2'b01);
        fp_cycle(2'b01, 2'b01);
        fp_req = 2'b10;
        fp_cycle(2'b10, 2'b01);
        fp_req = 2'b00;
        fp_cycle(2'b00, 2'b10);

        // randomized traffic against the model
        for (int h = 0; h < NH; h++) pend[h] = 0;
        req = '0; lock = '0;
        for (int n = 0; n < 400; n++) begin
            for (int h = 0; h < NH; h++) begin
                if (!pend[h]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[h] = 1;
                        set_host(h, 1, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                                 32'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom_range(1, 15)));
                    end else begin
                        req[h] = 1'b0;
                        lock[h] = 1'($urandom_range(0, 1));
                    end
                end
            end
            cycle();
            for (int h = 0; h < NH; h++) if (m_last_win == h) pend[h] = 0;
        end
        req = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_bus_arbiter.md
Name: gpio_bus_arbiter

Overview:
- Shares the single GPIO device register port between NumHosts bus hosts, for example the core data port and a debug/test host.
- Performs round-robin or fixed-priority arbitration with same-cycle grant.
- Routes each one-cycle-latency response back to the host that issued the request.
- Offers a per-host lock so a host can do an atomic read-modify-write of the GPIO output registers. A timeout breaks any lock that is held too long.
- Sits between the system bus host ports and the GPIO device port.

Parameters:
- NumHosts, 2: number of requesting hosts, 2..8.
- RoundRobin, 1: 1 selects round-robin; 0 selects fixed priority, where the lowest index wins.
- LockTimeout, 256: maximum number of cycles a lock may be held before forced release, >=2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- host_req_i  in  NumHosts  per-host request, held until granted
- host_lock_i  in  NumHosts  per-host lock request, sampled with a granted request
- host_addr_i  in  NumHosts*32  per-host address, flattened with host i at [32i+31:32i]
- host_we_i  in  NumHosts  per-host write enable
- host_be_i  in  NumHosts*4  per-host byte enables
- host_wdata_i  in  NumHosts*32  per-host write data
- host_gnt_o  out  NumHosts  one-hot grant
- host_rvalid_o  out  NumHosts  one-hot response valid
- host_rdata_o  out  32  response data, shared by all hosts and qualified by host_rvalid_o
- device_req_o  out  1  device request
- device_addr_o  out  32  device address
- device_we_o  out  1  device write enable
- device_be_o  out  4  device byte enables
- device_wdata_o  out  32  device write data
- device_rvalid_i  in  1  device response valid, asserted exactly 1 cycle after device_req_o
- device_rdata_i  in  32  device read data
- lock_err_o  out  1  sticky flag: a lock was force-released by timeout

Behaviour:
- Reset: reset is rst_ni, asynchronous, active-low; clock is clk_i.
  - Reset values: rr_ptr_q = NumHosts-1, so host 0 has highest round-robin priority first.
  - State = IDLE, lock_cnt_q = 0, lock_err_o = 0, resp_valid_q = 0, resp_idx_q = 0.
  - All outputs are 0 while in reset.
- Grant (combinational, same cycle as request):
  - IDLE state:
    - With RoundRobin=1, the winner is the first requesting host searching upward from rr_ptr_q+1, wrapping modulo NumHosts.
    - With RoundRobin=0, the winner is the lowest requesting index.
  - LOCKED state: only lock_owner_q may be granted. Other hosts' requests are stalled (gnt=0) even if the owner is idle.
  - host_gnt_o is one-hot or zero.
  - device_req_o = |host_gnt_o.
  - Device address, we, be and wdata are muxed from the winner. When there is no grant they are 0.
- Pointer: rr_ptr_q <= winner index on every grant, in both IDLE and LOCKED states.
- Response routing:
  - On grant: resp_idx_q <= winner and resp_valid_q <= 1. Otherwise resp_valid_q <= 0.
  - host_rvalid_o[resp_idx_q] = device_rvalid_i & resp_valid_q; all other bits are 0.
  - host_rdata_o = device_rdata_i.
  - Back-to-back grants every cycle are supported; there is no bubble.
- Lock FSM (states IDLE, LOCKED):
  - IDLE -> LOCKED: a granted host has host_lock_i=1. Set lock_owner_q <= winner and lock_cnt_q <= 0.
  - LOCKED -> IDLE (normal release): the owner is granted with host_lock_i=0. This final access completes normally.
  - LOCKED -> IDLE (timeout): lock_cnt_q reaches LockTimeout-1 with no release.
    - On that cycle, lock_err_o <= 1.
    - The owner is not granted on the timeout cycle; arbitration resumes the next cycle.
  - In LOCKED, lock_cnt_q increments every cycle and saturates at LockTimeout-1.
  - If the owner drops host_lock_i while its request is not asserted, nothing happens. Release only occurs on a granted access.
- lock_err_o stays set until reset; it has no clear path.
- Simultaneous events:
  - If a lock request and a timeout occur in the same cycle, the timeout takes precedence.
  - A new lock may be acquired on the first IDLE cycle after release.
- Reset asserted mid-transaction: a pending response is discarded. host_rvalid_o is 0 after reset, even if device_rvalid_i arrives.
- Requests must remain stable until granted. Behaviour is undefined if a host withdraws host_req_i before grant.

Test Plan:
- Single host: host0 write addr 0x0, wdata 0x00A5, be 0xF.
  - Required: gnt0 in the same cycle; device_req_o=1 with addr 0x0 and wdata 0x00A5.
  - Required: host_rvalid_o=0b01 one cycle later.
- Round-robin: NumHosts=2, RoundRobin=1, both hosts requesting continuously for 4 cycles.
  - Required grant sequence: 0, 1, 0, 1.
  - Required: rvalid follows one cycle behind each grant with the matching index.
- Fixed priority: RoundRobin=0, both hosts requesting for 3 cycles.
  - Required: host0 granted all 3 cycles; host1 granted in the first cycle host0 deasserts.
- Read routing: host1 reads addr 0x4 while the device returns rdata 0x0000003C.
  - Required: host_rvalid_o=0b10 and host_rdata_o=0x3C one cycle after gnt1.
- Lock:
  - Stimulus: host0 issues read 0x0 with lock=1, then host1 requests, then 3 cycles later host0 writes 0x0 with lock=0.
  - Required: host1 gnt=0 until host0's unlock write is granted; host1 is granted the next cycle; lock_err_o=0.
- Timeout: LockTimeout=8; host0 locks and then goes idle.
  - Required: host1 stalled for 8 cycles after lock acquisition, then granted.
  - Required: lock_err_o=1 and remains 1 until rst_ni is asserted.
